// File: rtl/fb_pkg.sv
// Shared frame buffer types: default geometry, coordinate/colour widths and
// the write scheduler state encoding.
package fb_pkg;

    localparam int FB_W_DEFAULT = 320;
    localparam int FB_H_DEFAULT = 240;

    typedef logic [8:0] coord_t;
    typedef logic [3:0] color_t;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : fb_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that was not granted most recently.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_r;

    // One-hot grant from the request vector and the last winner
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-winner pointer; reset favours requester 0 on the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;
        end else if (advance) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule : rr_arb2

// File: rtl/fb_write_sched.sv
// Frame buffer write scheduler: arbitrates rasterizer and sprite writes, and
// performs full-screen colour fills in raster order.
module fb_write_sched
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEFAULT,
    parameter int FB_H = FB_H_DEFAULT
) (
    input  logic            gpu_clk_150,
    input  logic            reset_n,
    input  logic            clear_start,
    input  logic [3:0]      clear_color,
    output logic            clear_busy,
    input  logic [1:0]      req_valid,
    input  logic [1:0][8:0] req_x,
    input  logic [1:0][8:0] req_y,
    input  logic [1:0][3:0] req_data,
    output logic [1:0]      req_ready,
    output logic [8:0]      fb_x,
    output logic [8:0]      fb_y,
    output logic [3:0]      fb_data,
    output logic            fb_we,
    output logic [15:0]     drop_count
);

    localparam coord_t X_LAST = coord_t'(FB_W - 1);
    localparam coord_t Y_LAST = coord_t'(FB_H - 1);

    state_t      state_r;
    state_t      state_s;
    coord_t      cnt_x_r;
    coord_t      cnt_y_r;
    color_t      fill_color_r;
    logic        fill_last_s;

    logic        serve_s;
    logic [1:0]  arb_valid_s;
    logic [1:0]  grant_s;
    logic        xfer_s;
    logic        sel_s;
    coord_t      sel_x_s;
    coord_t      sel_y_s;
    color_t      sel_data_s;
    logic        in_range_s;

    logic        we_s;
    coord_t      wx_s;
    coord_t      wy_s;
    color_t      wd_s;
    logic        drop_inc_s;

    logic        fb_we_r;
    coord_t      fb_x_r;
    coord_t      fb_y_r;
    color_t      fb_data_r;
    logic [15:0] drop_count_r;

    assign fill_last_s = (cnt_x_r == X_LAST) && (cnt_y_r == Y_LAST);
    // Requests are only eligible in SERVE, never alongside a clear request or in reset
    assign serve_s     = reset_n && (state_r == SERVE) && !clear_start;
    assign arb_valid_s = serve_s ? req_valid : 2'b00;
    assign xfer_s      = |grant_s;
    assign sel_s       = grant_s[1];
    assign sel_x_s     = req_x[sel_s];
    assign sel_y_s     = req_y[sel_s];
    assign sel_data_s  = req_data[sel_s];
    assign in_range_s  = (sel_x_s <= X_LAST) && (sel_y_s <= Y_LAST);

    rr_arb2 u_arb (
        .clk     (gpu_clk_150),
        .rst_n   (reset_n),
        .valid   (arb_valid_s),
        .advance (xfer_s),
        .grant   (grant_s)
    );

    // Next-state logic for the serve/fill controller
    always_comb begin
        state_s = state_r;
        case (state_r)
            SERVE: begin
                if (clear_start) state_s = CLEAR;
                else             state_s = SERVE;
            end
            CLEAR: begin
                if (fill_last_s) state_s = SERVE;
                else             state_s = CLEAR;
            end
            default: state_s = SERVE;
        endcase
    end

    // State register
    always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= SERVE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fill raster counters and latched fill colour
    always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_x_r      <= 9'd0;
            cnt_y_r      <= 9'd0;
            fill_color_r <= 4'd0;
        end else if ((state_r == SERVE) && clear_start) begin
            cnt_x_r      <= 9'd0;
            cnt_y_r      <= 9'd0;
            fill_color_r <= clear_color;
        end else if (state_r == CLEAR) begin
            if (cnt_x_r == X_LAST) begin
                cnt_x_r <= 9'd0;
                cnt_y_r <= fill_last_s ? 9'd0 : cnt_y_r + 9'd1;
            end else begin
                cnt_x_r <= cnt_x_r + 9'd1;
                cnt_y_r <= cnt_y_r;
            end
        end else begin
            cnt_x_r      <= cnt_x_r;
            cnt_y_r      <= cnt_y_r;
            fill_color_r <= fill_color_r;
        end
    end

    // Select this cycle's write: fill pixel, in-range transfer, or nothing (hold address/data)
    always_comb begin
        we_s       = 1'b0;
        wx_s       = fb_x_r;
        wy_s       = fb_y_r;
        wd_s       = fb_data_r;
        drop_inc_s = 1'b0;
        if (state_r == CLEAR) begin
            we_s = 1'b1;
            wx_s = cnt_x_r;
            wy_s = cnt_y_r;
            wd_s = fill_color_r;
        end else if (xfer_s) begin
            if (in_range_s) begin
                we_s = 1'b1;
                wx_s = sel_x_s;
                wy_s = sel_y_s;
                wd_s = sel_data_s;
            end else begin
                drop_inc_s = 1'b1;
            end
        end else begin
            we_s = 1'b0;
        end
    end

    // Registered frame buffer port and saturating drop counter
    always_ff @(posedge gpu_clk_150 or negedge reset_n) begin
        if (!reset_n) begin
            fb_we_r      <= 1'b0;
            fb_x_r       <= 9'd0;
            fb_y_r       <= 9'd0;
            fb_data_r    <= 4'd0;
            drop_count_r <= 16'd0;
        end else begin
            fb_we_r   <= we_s;
            fb_x_r    <= wx_s;
            fb_y_r    <= wy_s;
            fb_data_r <= wd_s;
            if (drop_inc_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    assign clear_busy = (state_r == CLEAR);
    assign req_ready  = grant_s;
    assign fb_we      = fb_we_r;
    assign fb_x       = fb_x_r;
    assign fb_y       = fb_y_r;
    assign fb_data    = fb_data_r;
    assign drop_count = drop_count_r;

endmodule : fb_write_sched

// File: tb/tb_fb_write_sched.sv
// Self-checking bench: a full-size instance for request traffic and a 4x3
// instance for fills, checked against a behavioural model of the rules.
module tb_fb_write_sched;

    localparam int D_W = 320;
    localparam int D_H = 240;

    logic gpu_clk_150 = 1'b0;
    logic reset_n;
    always #5 gpu_clk_150 = ~gpu_clk_150;

    logic            d_clear_start, s_clear_start;
    logic [3:0]      d_clear_color, s_clear_color;
    logic [1:0]      d_req_valid, s_req_valid;
    logic [1:0][8:0] d_req_x, d_req_y, s_req_x, s_req_y;
    logic [1:0][3:0] d_req_data, s_req_data;
    logic            d_clear_busy, s_clear_busy;
    logic [1:0]      d_req_ready, s_req_ready;
    logic [8:0]      d_fb_x, d_fb_y, s_fb_x, s_fb_y;
    logic [3:0]      d_fb_data, s_fb_data;
    logic            d_fb_we, s_fb_we;
    logic [15:0]     d_drop_count, s_drop_count;

    int vectors = 0;
    int miscompares = 0;

    fb_write_sched #(.FB_W(D_W), .FB_H(D_H)) u_dut (
        .gpu_clk_150 (gpu_clk_150), .reset_n (reset_n),
        .clear_start (d_clear_start), .clear_color (d_clear_color), .clear_busy (d_clear_busy),
        .req_valid (d_req_valid), .req_x (d_req_x), .req_y (d_req_y), .req_data (d_req_data),
        .req_ready (d_req_ready), .fb_x (d_fb_x), .fb_y (d_fb_y), .fb_data (d_fb_data),
        .fb_we (d_fb_we), .drop_count (d_drop_count)
    );

    fb_write_sched #(.FB_W(4), .FB_H(3)) u_small (
        .gpu_clk_150 (gpu_clk_150), .reset_n (reset_n),
        .clear_start (s_clear_start), .clear_color (s_clear_color), .clear_busy (s_clear_busy),
        .req_valid (s_req_valid), .req_x (s_req_x), .req_y (s_req_y), .req_data (s_req_data),
        .req_ready (s_req_ready), .fb_x (s_fb_x), .fb_y (s_fb_y), .fb_data (s_fb_data),
        .fb_we (s_fb_we), .drop_count (s_drop_count)
    );

    task automatic idle_inputs();
        d_clear_start = 1'b0; d_clear_color = 4'd0; d_req_valid = 2'b00;
        d_req_x = '0; d_req_y = '0; d_req_data = '0;
        s_clear_start = 1'b0; s_clear_color = 4'd0; s_req_valid = 2'b00;
        s_req_x = '0; s_req_y = '0; s_req_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge gpu_clk_150);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        d_req_valid = 2'b11; s_req_valid = 2'b11; d_clear_start = 1'b1;
        repeat (2) @(posedge gpu_clk_150);
        #1;
        vectors++;
        if ({d_clear_busy, d_req_ready, d_fb_we, d_fb_x, d_fb_y, d_fb_data, d_drop_count} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_full: got busy=%b rdy=%b we=%b x=%0d y=%0d d=%h drop=%0d want all zero",
                     d_clear_busy, d_req_ready, d_fb_we, d_fb_x, d_fb_y, d_fb_data, d_drop_count);
        end
        vectors++;
        if ({s_clear_busy, s_req_ready, s_fb_we, s_fb_x, s_fb_y, s_fb_data, s_drop_count} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_small: got busy=%b rdy=%b we=%b x=%0d y=%0d d=%h drop=%0d want all zero",
                     s_clear_busy, s_req_ready, s_fb_we, s_fb_x, s_fb_y, s_fb_data, s_drop_count);
        end
        idle_inputs();
        @(posedge gpu_clk_150);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_idle_single();
        apply_reset();
        d_req_valid = 2'b01;
        d_req_x[0] = 9'd5; d_req_y[0] = 9'd7; d_req_data[0] = 4'd3;
        d_req_x[1] = 9'd100; d_req_y[1] = 9'd50; d_req_data[1] = 4'd9;
        #1;
        vectors++;
        if (d_req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL idle_ready: got %b want 01", d_req_ready);
        end
        @(posedge gpu_clk_150); #1;
        d_req_valid = 2'b00;
        vectors++;
        if ({d_fb_we, d_fb_x, d_fb_y, d_fb_data} !== {1'b1, 9'd5, 9'd7, 4'd3}) begin
            miscompares++;
            $display("FAIL idle_write: got we=%b (%0d,%0d,%h) want we=1 (5,7,3)", d_fb_we, d_fb_x, d_fb_y, d_fb_data);
        end
        @(posedge gpu_clk_150); #1;
        vectors++;
        if ({d_fb_we, d_fb_x, d_fb_y, d_fb_data} !== {1'b0, 9'd5, 9'd7, 4'd3}) begin
            miscompares++;
            $display("FAIL idle_hold: got we=%b (%0d,%0d,%h) want we=0 (5,7,3)", d_fb_we, d_fb_x, d_fb_y, d_fb_data);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        logic [8:0] ex, ey;
        logic [3:0] ed;
        int wr;
        apply_reset();
        d_req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) begin
                d_req_x[r]    = 9'($urandom_range(0, D_W - 1));
                d_req_y[r]    = 9'($urandom_range(0, D_H - 1));
                d_req_data[r] = 4'($urandom_range(0, 15));
            end
            #1;
            wr    = k % 2;
            exp_g = (wr == 0) ? 2'b01 : 2'b10;
            ex = d_req_x[wr]; ey = d_req_y[wr]; ed = d_req_data[wr];
            vectors++;
            if (d_req_ready !== exp_g) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got %b want %b", k, d_req_ready, exp_g);
            end
            @(posedge gpu_clk_150); #1;
            vectors++;
            if ({d_fb_we, d_fb_x, d_fb_y, d_fb_data} !== {1'b1, ex, ey, ed}) begin
                miscompares++;
                $display("FAIL contention_write[%0d]: got we=%b (%0d,%0d,%h) want we=1 (%0d,%0d,%h)",
                         k, d_fb_we, d_fb_x, d_fb_y, d_fb_data, ex, ey, ed);
            end
        end
        d_req_valid = 2'b00;
    endtask

    task automatic test_random();
        int last_win;
        int g;
        int exp_drop;
        logic       exp_we;
        logic [8:0] ex, ey;
        logic [3:0] ed;
        logic [1:0] exp_ready;
        apply_reset();
        last_win = 1; exp_drop = 0; exp_we = 1'b0; ex = 9'd0; ey = 9'd0; ed = 4'd0;
        for (int n = 0; n < 400; n++) begin
            d_req_valid = 2'($urandom_range(0, 3));
            for (int r = 0; r < 2; r++) begin
                d_req_x[r] = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(D_W, 511)) : 9'($urandom_range(0, D_W - 1));
                d_req_y[r] = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(D_H, 511)) : 9'($urandom_range(0, D_H - 1));
                d_req_data[r] = 4'($urandom_range(0, 15));
            end
            #1;
            case (d_req_valid)
                2'b01:   g = 0;
                2'b10:   g = 1;
                2'b11:   g = (last_win == 0) ? 1 : 0;
                default: g = -1;
            endcase
            exp_ready = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            vectors++;
            if (d_req_ready !== exp_ready) begin
                miscompares++;
                $display("FAIL random_ready[%0d]: got %b want %b", n, d_req_ready, exp_ready);
            end
            if (g >= 0) begin
                last_win = g;
                if ((int'(d_req_x[g]) < D_W) && (int'(d_req_y[g]) < D_H)) begin
                    exp_we = 1'b1; ex = d_req_x[g]; ey = d_req_y[g]; ed = d_req_data[g];
                end else begin
                    exp_we = 1'b0;
                    if (exp_drop < 65535) exp_drop++;
                end
            end else begin
                exp_we = 1'b0;
            end
            @(posedge gpu_clk_150); #1;
            vectors++;
            if ({d_fb_we, d_fb_x, d_fb_y, d_fb_data, d_drop_count} !== {exp_we, ex, ey, ed, 16'(exp_drop)}) begin
                miscompares++;
                $display("FAIL random_write[%0d]: got we=%b (%0d,%0d,%h) drop=%0d want we=%b (%0d,%0d,%h) drop=%0d",
                         n, d_fb_we, d_fb_x, d_fb_y, d_fb_data, d_drop_count, exp_we, ex, ey, ed, exp_drop);
            end
        end
        d_req_valid = 2'b00;
    endtask

    task automatic test_out_of_range();
        apply_reset();
        d_req_valid = 2'b01;
        d_req_x[0] = 9'd320; d_req_y[0] = 9'd10; d_req_data[0] = 4'd9;
        #1;
        vectors++;
        if (d_req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL oor_ready: got %b want 01", d_req_ready);
        end
        @(posedge gpu_clk_150); #1;
        vectors++;
        if ({d_fb_we, d_fb_x, d_fb_y, d_fb_data, d_drop_count} !== {1'b0, 9'd0, 9'd0, 4'd0, 16'd1}) begin
            miscompares++;
            $display("FAIL oor_first: got we=%b (%0d,%0d,%h) drop=%0d want we=0 (0,0,0) drop=1",
                     d_fb_we, d_fb_x, d_fb_y, d_fb_data, d_drop_count);
        end
        d_req_x[0] = 9'd5; d_req_y[0] = 9'd240;
        @(posedge gpu_clk_150); #1;
        vectors++;
        if ({d_fb_we, d_drop_count} !== {1'b0, 16'd2}) begin
            miscompares++;
            $display("FAIL oor_y: got we=%b drop=%0d want we=0 drop=2", d_fb_we, d_drop_count);
        end
        d_req_x[0] = 9'd320; d_req_y[0] = 9'd10;
        repeat (65533) @(posedge gpu_clk_150);
        #1;
        vectors++;
        if (d_drop_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL oor_reach_max: got %h want ffff", d_drop_count);
        end
        repeat (4) @(posedge gpu_clk_150);
        #1;
        vectors++;
        if ({d_fb_we, d_drop_count} !== {1'b0, 16'hFFFF}) begin
            miscompares++;
            $display("FAIL oor_saturate: got we=%b drop=%h want we=0 drop=ffff", d_fb_we, d_drop_count);
        end
        d_req_valid = 2'b00;
    endtask

    task automatic test_fill();
        logic [8:0] ex, ey;
        apply_reset();
        s_clear_start = 1'b1; s_clear_color = 4'hA;
        s_req_valid = 2'b11;
        s_req_x[0] = 9'd1; s_req_y[0] = 9'd1; s_req_x[1] = 9'd2; s_req_y[1] = 9'd2;
        s_req_data[0] = 4'd1; s_req_data[1] = 4'd2;
        #1;
        vectors++;
        if (s_req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL fill_start_ready: got %b want 00", s_req_ready);
        end
        @(posedge gpu_clk_150); #1;
        s_clear_color = 4'h3;
        for (int i = 0; i < 12; i++) begin
            s_clear_start = (i == 5) ? 1'b1 : 1'b0;
            #1;
            vectors++;
            if ({s_clear_busy, s_req_ready} !== 3'b100) begin
                miscompares++;
                $display("FAIL fill_busy[%0d]: got busy=%b rdy=%b want busy=1 rdy=00", i, s_clear_busy, s_req_ready);
            end
            if (i == 0) begin
                vectors++;
                if (s_fb_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fill_first_we: got %b want 0", s_fb_we);
                end
            end else begin
                ex = 9'((i - 1) % 4);
                ey = 9'((i - 1) / 4);
                vectors++;
                if ({s_fb_we, s_fb_x, s_fb_y, s_fb_data} !== {1'b1, ex, ey, 4'hA}) begin
                    miscompares++;
                    $display("FAIL fill_write[%0d]: got we=%b (%0d,%0d,%h) want we=1 (%0d,%0d,a)",
                             i, s_fb_we, s_fb_x, s_fb_y, s_fb_data, ex, ey);
                end
            end
            @(posedge gpu_clk_150); #1;
        end
        s_clear_start = 1'b0; s_req_valid = 2'b00;
        vectors++;
        if ({s_clear_busy, s_fb_we, s_fb_x, s_fb_y, s_fb_data} !== {1'b0, 1'b1, 9'd3, 9'd2, 4'hA}) begin
            miscompares++;
            $display("FAIL fill_last: got busy=%b we=%b (%0d,%0d,%h) want busy=0 we=1 (3,2,a)",
                     s_clear_busy, s_fb_we, s_fb_x, s_fb_y, s_fb_data);
        end
        @(posedge gpu_clk_150); #1;
        vectors++;
        if ({s_clear_busy, s_fb_we, s_fb_x, s_fb_y, s_fb_data} !== {1'b0, 1'b0, 9'd3, 9'd2, 4'hA}) begin
            miscompares++;
            $display("FAIL fill_done: got busy=%b we=%b (%0d,%0d,%h) want busy=0 we=0 (3,2,a)",
                     s_clear_busy, s_fb_we, s_fb_x, s_fb_y, s_fb_data);
        end
    endtask

    task automatic test_simul_abort();
        apply_reset();
        s_clear_start = 1'b1; s_clear_color = 4'h5;
        s_req_valid = 2'b01; s_req_x[0] = 9'd1; s_req_y[0] = 9'd1; s_req_data[0] = 4'd7;
        #1;
        vectors++;
        if (s_req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_ready: got %b want 00", s_req_ready);
        end
        @(posedge gpu_clk_150); #1;
        s_clear_start = 1'b0; s_req_valid = 2'b00;
        vectors++;
        if (s_clear_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_busy: got %b want 1", s_clear_busy);
        end
        repeat (3) @(posedge gpu_clk_150);
        #1;
        vectors++;
        if (s_fb_we !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_prefill_we: got %b want 1", s_fb_we);
        end
        #2;
        s_req_valid = 2'b01;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({s_clear_busy, s_fb_we, s_req_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_immediate: got busy=%b we=%b rdy=%b want 0 0 00", s_clear_busy, s_fb_we, s_req_ready);
        end
        @(posedge gpu_clk_150); #1;
        reset_n = 1'b1; s_req_valid = 2'b00;
        @(posedge gpu_clk_150); #1;
        vectors++;
        if ({s_clear_busy, s_fb_we} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_after: got busy=%b we=%b want 0 0", s_clear_busy, s_fb_we);
        end
        s_req_valid = 2'b01; s_req_x[0] = 9'd2; s_req_y[0] = 9'd1; s_req_data[0] = 4'd5;
        #1;
        vectors++;
        if (s_req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL abort_accept_ready: got %b want 01", s_req_ready);
        end
        @(posedge gpu_clk_150); #1;
        s_req_valid = 2'b00;
        vectors++;
        if ({s_fb_we, s_fb_x, s_fb_y, s_fb_data} !== {1'b1, 9'd2, 9'd1, 4'd5}) begin
            miscompares++;
            $display("FAIL abort_accept_write: got we=%b (%0d,%0d,%h) want we=1 (2,1,5)", s_fb_we, s_fb_x, s_fb_y, s_fb_data);
        end
    endtask

    initial begin
        test_reset();
        test_idle_single();
        test_contention();
        test_random();
        test_out_of_range();
        test_fill();
        test_simul_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fb_write_sched
